// File: rtl/player_mover_if.sv
// Move-request handshake between a requester and the player_mover block.
interface player_mover_if;
   logic       req_valid;
   logic       req_ready;
   logic [9:0] target_x;
   logic [9:0] target_y;

   modport master (
      output req_valid,
      output target_x,
      output target_y,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  target_x,
      input  target_y,
      output req_ready
   );
endinterface

// File: rtl/player_mover.sv
// Moves a 16x16 sprite toward a requested position, one step per frame tick.
// X is resolved first, then Y, then the block waits a number of frame ticks
// before pulsing move_done and accepting the next request.
module player_mover #(
   parameter logic [9:0]  INIT_X        = 10'd32,
   parameter logic [9:0]  INIT_Y        = 10'd32,
   parameter int unsigned STEP_PX       = 2,
   parameter int unsigned SETTLE_FRAMES = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          frame_tick,
   player_mover_if.slave req,
   output logic [9:0]    player_x,
   output logic [9:0]    player_y,
   output logic          busy,
   output logic          move_done
);

   // Largest top-left corner that keeps the sprite inside 640x480.
   localparam logic [9:0]  MaxX      = 10'd624;
   localparam logic [9:0]  MaxY      = 10'd464;
   localparam logic [9:0]  StepPx    = 10'(STEP_PX);
   localparam logic [10:0] StepMag   = 11'(STEP_PX);
   localparam logic [7:0]  SettleCnt = 8'(SETTLE_FRAMES);

   typedef enum logic [2:0] {
      StIdle,
      StMoveX,
      StMoveY,
      StSettle,
      StDone
   } state_e;

   state_e     state_q, state_d;
   logic [9:0] x_q, x_d;
   logic [9:0] y_q, y_d;
   logic [9:0] tx_q, tx_d;
   logic [9:0] ty_q, ty_d;
   logic [7:0] cnt_q, cnt_d;
   logic       handshake;

   // One step toward tgt; the difference is 11-bit signed so it cannot wrap,
   // and a remaining distance within one step lands exactly on the target.
   function automatic logic [9:0] step_toward(input logic [9:0] cur, input logic [9:0] tgt);
      logic signed [10:0] diff;
      logic [10:0]        mag;
      diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
      mag  = diff[10] ? 11'(-diff) : 11'(diff);
      if (mag <= StepMag) begin
         step_toward = tgt;
      end else if (diff[10]) begin
         step_toward = cur - StepPx;
      end else begin
         step_toward = cur + StepPx;
      end
   endfunction

   // Ready is masked by reset so it stays low while reset is held.
   assign req.req_ready = (state_q == StIdle) && !reset;
   assign handshake     = req.req_valid && req.req_ready;

   assign player_x  = x_q;
   assign player_y  = y_q;
   assign busy      = (state_q != StIdle);
   assign move_done = (state_q == StDone);

   // State and position registers; reset abandons any move immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         x_q     <= INIT_X;
         y_q     <= INIT_Y;
         tx_q    <= INIT_X;
         ty_q    <= INIT_Y;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         tx_q    <= tx_d;
         ty_q    <= ty_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state, position stepping and settle counting.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      tx_d    = tx_q;
      ty_d    = ty_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            cnt_d = 8'd0;
            if (handshake) begin
               tx_d    = (req.target_x > MaxX) ? MaxX : req.target_x;
               ty_d    = (req.target_y > MaxY) ? MaxY : req.target_y;
               state_d = StMoveX;
            end
         end
         StMoveX: begin
            // Arrival is checked before stepping, so the hand-off to Y is
            // the cycle after the last step and never waits for a tick.
            if (x_q == tx_q) begin
               state_d = StMoveY;
            end else if (frame_tick) begin
               x_d = step_toward(x_q, tx_q);
            end
         end
         StMoveY: begin
            if (y_q == ty_q) begin
               state_d = StSettle;
               cnt_d   = 8'd0;
            end else if (frame_tick) begin
               y_d = step_toward(y_q, ty_q);
            end
         end
         StSettle: begin
            if (cnt_q == SettleCnt) begin
               state_d = StDone;
            end else if (frame_tick) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

endmodule

// File: tb/tb_player_mover.sv
// Scoreboard bench for player_mover: two instances (default parameters, and
// STEP_PX=4 / SETTLE_FRAMES=0). Requests push the expected path of positions
// and the expected completion into queues; a negedge monitor pops and compares.
module tb_player_mover;

   localparam int InitX = 32;
   localparam int InitY = 32;

   typedef struct {
      int dut;
      int x;
      int y;
      int settle;
      bit same;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       frame_tick;
   logic [9:0] p0x, p0y, p1x, p1y;
   logic       busy0, busy1, done0, done1;

   int   vectors = 0;
   int   errors  = 0;
   int   cyc     = 0;
   int   tick_period = 10;
   int   tick_cnt    = 0;
   exp_t path_q[$];
   exp_t done_q[$];
   int   mx[2], my[2];
   int   step_of[2];
   int   settle_of[2];
   int   last_x[2], last_y[2], ev_cyc[2], hs_cyc[2], ticks[2], done_cnt[2];
   logic prev_hs[2], prev_done[2];
   logic prev_tick = 1'b0;

   player_mover_if if0();
   player_mover_if if1();

   player_mover u_dut0 (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .req        (if0),
      .player_x   (p0x),
      .player_y   (p0y),
      .busy       (busy0),
      .move_done  (done0)
   );

   player_mover #(
      .STEP_PX       (4),
      .SETTLE_FRAMES (0)
   ) u_dut1 (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .req        (if1),
      .player_x   (p1x),
      .player_y   (p1y),
      .busy       (busy1),
      .move_done  (done1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      vectors++;
      errors++;
      $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
   endtask

   // Frame tick generator: one-cycle pulse every tick_period cycles (>= 3).
   initial begin
      frame_tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         tick_cnt++;
         if (tick_cnt >= tick_period) begin
            tick_cnt   = 0;
            frame_tick = 1'b1;
         end else begin
            frame_tick = 1'b0;
         end
      end
   end

   // Per-instance monitor; position values are compared as x*1000+y.
   task automatic mon(input int k, input logic [9:0] px, input logic [9:0] py,
                      input logic done, input logic hs);
      exp_t e;
      bit   changed;
      if (reset) begin
         last_x[k]    = InitX;
         last_y[k]    = InitY;
         prev_hs[k]   = 1'b0;
         prev_done[k] = 1'b0;
         return;
      end
      changed = (int'(px) != last_x[k]) || (int'(py) != last_y[k]);
      if (done) begin
         chk($sformatf("done_single_cycle_dut%0d", k), int'(prev_done[k]), 0);
         if (!prev_done[k]) begin
            done_cnt[k]++;
            if (done_q.size() == 0 || done_q[0].dut != k) begin
               fail_now($sformatf("spurious_done_dut%0d", k));
            end else begin
               e = done_q.pop_front();
               chk($sformatf("final_pos_dut%0d", k), int'(px) * 1000 + int'(py),
                   e.x * 1000 + e.y);
               chk($sformatf("settle_ticks_dut%0d", k), ticks[k], e.settle);
               if (e.same && e.settle == 0)
                  chk("same_pos_done_within_5", int'((cyc - hs_cyc[k]) <= 5), 1);
            end
         end
      end
      if (changed) begin
         chk($sformatf("move_on_tick_dut%0d", k), int'(prev_tick), 1);
         if (path_q.size() == 0 || path_q[0].dut != k) begin
            fail_now($sformatf("spurious_move_dut%0d", k));
         end else begin
            e = path_q.pop_front();
            chk($sformatf("path_dut%0d", k), int'(px) * 1000 + int'(py), e.x * 1000 + e.y);
         end
         ev_cyc[k] = cyc;
         ticks[k]  = 0;
      end else if (prev_hs[k]) begin
         ev_cyc[k] = cyc;
         hs_cyc[k] = cyc;
         ticks[k]  = 0;
      end else if (prev_tick && (cyc - ev_cyc[k]) >= 3) begin
         ticks[k]++;
      end
      prev_hs[k]   = hs;
      prev_done[k] = done;
      last_x[k]    = int'(px);
      last_y[k]    = int'(py);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         done_cnt[k] = 0;
         ticks[k]    = 0;
         ev_cyc[k]   = 0;
         hs_cyc[k]   = 0;
      end
      forever begin
         @(negedge clk);
         cyc++;
         mon(0, p0x, p0y, done0, if0.req_valid && if0.req_ready);
         mon(1, p1x, p1y, done1, if1.req_valid && if1.req_ready);
         prev_tick = frame_tick;
      end
   end

   function automatic logic ready_of(input int k);
      return (k == 0) ? if0.req_ready : if1.req_ready;
   endfunction

   task automatic drive(input int k, input logic v, input int tx, input int ty);
      if (k == 0) begin
         if0.req_valid = v;
         if0.target_x  = 10'(tx);
         if0.target_y  = 10'(ty);
      end else begin
         if1.req_valid = v;
         if1.target_x  = 10'(tx);
         if1.target_y  = 10'(ty);
      end
   endtask

   // Reference model: Manhattan walk, x then y, clamped target, exact landing.
   task automatic model_push(input int k, input int tx, input int ty);
      int cx, cy, x, y, d, s;
      bit same;
      cx   = (tx > 624) ? 624 : tx;
      cy   = (ty > 464) ? 464 : ty;
      x    = mx[k];
      y    = my[k];
      s    = step_of[k];
      same = (x == cx) && (y == cy);
      while (x != cx) begin
         d = cx - x;
         if (d >= -s && d <= s) x = cx;
         else x = x + ((d > 0) ? s : -s);
         path_q.push_back('{k, x, y, 0, 1'b0});
      end
      while (y != cy) begin
         d = cy - y;
         if (d >= -s && d <= s) y = cy;
         else y = y + ((d > 0) ? s : -s);
         path_q.push_back('{k, x, y, 0, 1'b0});
      end
      done_q.push_back('{k, cx, cy, settle_of[k], same});
      mx[k] = cx;
      my[k] = cy;
   endtask

   task automatic start_req(input int k, input int tx, input int ty);
      int n = 0;
      while (!ready_of(k) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!ready_of(k)) fail_now($sformatf("ready_timeout_dut%0d", k));
      @(posedge clk);
      #1;
      drive(k, 1'b1, tx, ty);
      model_push(k, tx, ty);
      @(posedge clk);
      #1;
      drive(k, 1'b0, 0, 0);
   endtask

   task automatic wait_done(input int k, input int start);
      int n = 0;
      while (done_cnt[k] == start && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (done_cnt[k] == start) begin
         fail_now($sformatf("done_timeout_dut%0d", k));
         path_q.delete();
         done_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic move(input int k, input int tx, input int ty);
      int start;
      start = done_cnt[k];
      start_req(k, tx, ty);
      wait_done(k, start);
   endtask

   initial begin
      int start, n;
      step_of[0]   = 2;
      step_of[1]   = 4;
      settle_of[0] = 4;
      settle_of[1] = 0;
      for (int k = 0; k < 2; k++) begin
         mx[k] = InitX;
         my[k] = InitY;
      end
      drive(0, 1'b0, 0, 0);
      drive(1, 1'b0, 0, 0);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_pos0", int'(p0x) * 1000 + int'(p0y), InitX * 1000 + InitY);
      chk("reset_pos1", int'(p1x) * 1000 + int'(p1y), InitX * 1000 + InitY);
      chk("reset_busy", int'(busy0 | busy1), 0);
      chk("reset_done", int'(done0 | done1), 0);
      chk("reset_ready", int'(if0.req_ready | if1.req_ready), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", int'(if0.req_ready), 1);

      // Horizontal move, one tick every 10 cycles.
      move(0, 100, 32);
      // Off-screen request is clamped.
      tick_period = 4;
      move(0, 700, 500);
      // Requests while busy are refused and have no effect.
      start = done_cnt[0];
      start_req(0, 200, 100);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         drive(0, 1'b1, $urandom_range(0, 1023), $urandom_range(0, 1023));
         @(negedge clk);
         chk("ready_low_while_busy", int'(if0.req_ready), 0);
      end
      drive(0, 1'b0, 0, 0);
      wait_done(0, start);
      // Target equal to the current position.
      move(0, 200, 100);
      // Randomised moves with varying frame rates.
      for (int i = 0; i < 6; i++) begin
         tick_period = $urandom_range(3, 6);
         move(0, $urandom_range(0, 1023), $urandom_range(0, 1023));
      end

      // Reset in the middle of MOVE_Y at (100,50).
      tick_period = 3;
      move(0, 100, 20);
      start = done_cnt[0];
      start_req(0, 100, 80);
      n = 0;
      while (!(p0x == 10'd100 && p0y == 10'd50) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("reached_100_50", int'(p0x) * 1000 + int'(p0y), 100050);
      #2;
      reset = 1'b1;
      #1;
      chk("async_reset_pos", int'(p0x) * 1000 + int'(p0y), InitX * 1000 + InitY);
      chk("async_reset_busy", int'(busy0), 0);
      chk("async_reset_ready", int'(if0.req_ready), 0);
      path_q.delete();
      done_q.delete();
      mx[0] = InitX;
      my[0] = InitY;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (60) @(negedge clk);
      chk("no_done_after_abort", done_cnt[0] - start, 0);
      chk("pos_held_after_abort", int'(p0x) * 1000 + int'(p0y), InitX * 1000 + InitY);

      // STEP_PX=4, SETTLE_FRAMES=0 instance.
      tick_period = 4;
      start = done_cnt[1];
      start_req(1, 35, 40);
      n = 0;
      while (done_cnt[1] == start && n < 500) begin
         @(negedge clk);
         if (done_cnt[1] == start) chk("busy_during_move", int'(busy1), 1);
         n++;
      end
      wait_done(1, start);
      move(1, 35, 40);
      for (int i = 0; i < 3; i++) move(1, $urandom_range(0, 1023), $urandom_range(0, 700));

      chk("path_queue_drained", path_q.size(), 0);
      chk("done_queue_drained", done_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
